// File: rtl/cla_nibble_seq_adder.sv
// Multi-cycle W-bit adder/subtractor that reuses one 4-bit carry-lookahead slice per nibble,
// LSB first, with valid/ready handshakes on both the operand and the result side.

module CLA_Add_old4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cIn,
  output logic [3:0] s,
  output logic       cOut
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = x & y;
  assign p = x ^ y;

  // Every carry is formed directly from generate/propagate terms; there is no ripple.
  assign c[0] = cIn;
  assign c[1] = g[0] | (p[0] & cIn);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cIn);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cIn);
  assign cOut = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cIn);
  assign s = p ^ c;
endmodule

module cla_nibble_seq_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 sub,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cOut,
  output logic                 ovf,
  output logic                 zero
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [W-1:0]     op_a_reg;
  logic [W-1:0]     op_b_reg;
  logic             carry_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [W-1:0]     sum_reg;
  logic             c_out_reg;
  logic             ovf_reg;
  logic             zero_reg;

  logic [3:0]       slice_x;
  logic [3:0]       slice_y;
  logic [3:0]       slice_s;
  logic             slice_c;
  logic [W-1:0]     sum_next;
  logic             last_nibble;
  logic             accept;

  assign slice_x = op_a_reg[{idx_reg, 2'b00} +: 4];
  assign slice_y = op_b_reg[{idx_reg, 2'b00} +: 4];

  CLA_Add_old4 u_slice (
    .x    (slice_x),
    .y    (slice_y),
    .cIn  (carry_reg),
    .s    (slice_s),
    .cOut (slice_c)
  );

  // Only the nibble currently selected by idx_reg is replaced; the rest keep earlier results.
  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_sum_next
      assign sum_next[4*gi +: 4] = (idx_reg == IDX_W'(gi)) ? slice_s : sum_reg[4*gi +: 4];
    end
  endgenerate

  assign last_nibble = (idx_reg == IDX_W'(NIBBLES - 1));
  assign inReady     = (state_reg == IDLE) || ((state_reg == DONE) && outReady);
  assign outValid    = (state_reg == DONE);
  assign accept      = inValid && inReady;

  assign sum  = sum_reg;
  assign cOut = c_out_reg;
  assign ovf  = ovf_reg;
  assign zero = zero_reg;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
      c_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      zero_reg  <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1, with the +1 injected as the first carry-in.
      op_a_reg  <= a;
      op_b_reg  <= b ^ {W{sub}};
      carry_reg <= sub;
      idx_reg   <= '0;
      sum_reg   <= '0;
      state_reg <= RUN;
    end else if (state_reg == RUN) begin
      sum_reg   <= sum_next;
      carry_reg <= slice_c;
      if (last_nibble) begin
        idx_reg   <= '0;
        c_out_reg <= slice_c;
        ovf_reg   <= (op_a_reg[W-1] == op_b_reg[W-1]) && (slice_s[3] != op_a_reg[W-1]);
        zero_reg  <= (sum_next == '0);
        state_reg <= DONE;
      end else begin
        idx_reg <= idx_reg + IDX_W'(1);
      end
    end else if ((state_reg == DONE) && outReady) begin
      state_reg <= IDLE;
    end
  end
endmodule

// File: tb/tb_cla_nibble_seq_adder.sv
// Self-checking bench: directed scenarios plus a randomized regression, with a scoreboard
// that checks every result and its latency against a W-bit arithmetic reference.

module tb_cla_nibble_seq_adder;
  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rstN;
  logic         inValid;
  logic         inReady;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         outValid;
  logic         outReady;
  logic [W-1:0] sum;
  logic         cOut;
  logic         ovf;
  logic         zero;

  cla_nibble_seq_adder #(.NIBBLES(NIBBLES)) dut (
    .clk      (clk),
    .rstN     (rstN),
    .inValid  (inValid),
    .inReady  (inReady),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .outValid (outValid),
    .outReady (outReady),
    .sum      (sum),
    .cOut     (cOut),
    .ovf      (ovf),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    logic         z;
    int           t;
  } exp_t;

  exp_t         sb[$];
  int           errors  = 0;
  int           checks  = 0;
  int           cyc     = 0;
  int           results = 0;
  bit           ov_first = 1'b1;
  logic [W-1:0] last_sum;
  logic         last_c;
  logic         last_o;
  logic         last_z;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic s, input int t);
    logic [W:0] full;
    exp_t       e;
    full = {1'b0, x} + {1'b0, (s ? ~y : y)} + (W+1)'(s);
    e.s  = full[W-1:0];
    e.c  = full[W];
    if (s) e.o = (x[W-1] != y[W-1]) && (e.s[W-1] != x[W-1]);
    else   e.o = (x[W-1] == y[W-1]) && (e.s[W-1] != x[W-1]);
    e.z  = (e.s == '0);
    e.t  = t;
    return e;
  endfunction

  // Scoreboard monitor: checks held outputs every valid cycle, pops on consume, pushes on accept.
  always @(negedge clk) begin
    if (!rstN) begin
      sb.delete();
      ov_first = 1'b1;
    end else begin
      if (outValid) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_result", 32'(sb.size()), 32'd1);
        end else begin
          if (ov_first) chk("latency", 32'(cyc), 32'(sb[0].t + NIBBLES + 1));
          ov_first = 1'b0;
          chk("sum",  32'(sum),  32'(sb[0].s));
          chk("cout", 32'(cOut), 32'(sb[0].c));
          chk("ovf",  32'(ovf),  32'(sb[0].o));
          chk("zero", 32'(zero), 32'(sb[0].z));
          if (outReady) begin
            $display("result %0d: sum=%h cOut=%b ovf=%b zero=%b cycle=%0d",
                     results, sum, cOut, ovf, zero, cyc);
            last_sum = sum;
            last_c   = cOut;
            last_o   = ovf;
            last_z   = zero;
            void'(sb.pop_front());
            ov_first = 1'b1;
            results++;
          end
        end
      end
      if (inValid && inReady) sb.push_back(model(a, b, sub, cyc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands until accepted; optionally randomize outReady every cycle.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                      input bit rnd);
    bit took = 1'b0;
    a       = av;
    b       = bv;
    sub     = sv;
    inValid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (rnd) outReady = ($urandom_range(0, 3) != 0);
      #0;
      took = inReady;
      step();
      if (took) break;
    end
    inValid = 1'b0;
    if (!took) chk("send_timeout", 32'(took), 32'd1);
  endtask

  task automatic drain(input bit rnd);
    bit done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !outValid) begin
        done = 1'b1;
        break;
      end
      outReady = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      step();
    end
    if (!done) chk("drain_timeout", 32'(done), 32'd1);
    outReady = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstN     = 1'b0;
    inValid  = 1'b0;
    a        = '0;
    b        = '0;
    sub      = 1'b0;
    outReady = 1'b1;
    step();
    step();
    rstN = 1'b1;

    chk("rst_out_valid", 32'(outValid), 32'd0);
    chk("rst_in_ready",  32'(inReady),  32'd1);
    chk("rst_sum",       32'(sum),      32'd0);
    chk("rst_flags",     32'({cOut, ovf, zero}), 32'd0);

    // Basic add
    send(16'h1234, 16'h4321, 1'b0, 1'b0);
    drain(1'b0);
    chk("basic_sum",   32'(last_sum), 32'h5555);
    chk("basic_flags", 32'({last_c, last_o, last_z}), 32'b000);

    // Carry ripples through all four slice iterations
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    drain(1'b0);
    chk("ripple_sum",   32'(last_sum), 32'h0000);
    chk("ripple_flags", 32'({last_c, last_o, last_z}), 32'b101);

    // Subtract with and without overflow
    send(16'h8000, 16'h0001, 1'b1, 1'b0);
    drain(1'b0);
    chk("subovf_sum",   32'(last_sum), 32'h7FFF);
    chk("subovf_flags", 32'({last_c, last_o, last_z}), 32'b110);
    send(16'h0003, 16'h0005, 1'b1, 1'b0);
    drain(1'b0);
    chk("subneg_sum",   32'(last_sum), 32'hFFFE);
    chk("subneg_flags", 32'({last_c, last_o, last_z}), 32'b000);

    // Backpressure, then back-to-back accept in the consuming cycle
    outReady = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (outValid) break;
      step();
    end
    chk("bp_out_valid", 32'(outValid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", 32'(inReady), 32'd0);
      a       = W'($urandom);
      b       = W'($urandom);
      sub     = 1'($urandom);
      inValid = 1'b1;
      step();
    end
    a        = 16'h0F0F;
    b        = 16'h0101;
    sub      = 1'b0;
    inValid  = 1'b1;
    outReady = 1'b1;
    #0;
    chk("b2b_in_ready", 32'(inReady), 32'd1);
    step();
    inValid = 1'b0;
    chk("b2b_out_valid_drop", 32'(outValid), 32'd0);
    chk("bp_consumed_sum", 32'(last_sum), 32'h3333);
    drain(1'b0);
    chk("b2b_sum", 32'(last_sum), 32'h1010);

    // Reset while in RUN at idx 2
    send(16'h1234, 16'h1111, 1'b0, 1'b0);
    step();
    step();
    rstN = 1'b0;
    step();
    rstN = 1'b1;
    chk("midrst_out_valid", 32'(outValid), 32'd0);
    chk("midrst_in_ready",  32'(inReady),  32'd1);
    chk("midrst_sum",       32'(sum),      32'd0);
    chk("midrst_flags",     32'({cOut, ovf, zero}), 32'd0);
    send(16'h0002, 16'h0003, 1'b0, 1'b0);
    drain(1'b0);
    chk("midrst_fresh_sum", 32'(last_sum), 32'h0005);

    // Random regression with random consumer stalls
    for (int i = 0; i < 1000; i++)
      send(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    drain(1'b1);
    chk("results_total", 32'(results), 32'd1007);
    chk("sb_empty_at_end", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cla_nibble_seq_adder.md
# cla_nibble_seq_adder

Multi-cycle W-bit adder/subtractor sequencer. It reuses one 4-bit carry-lookahead slice, `CLA_Add_old4`, once per nibble, LSB nibble first, and carries the slice's `cOut` between cycles in a register. It sits between an operand producer and a result consumer, both on valid/ready handshakes. This lets wide operands share a single small CLA datapath instead of replicating the slice.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices per operand. Operand width W = 4*NIBBLES. Legal range is ≥ 2.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rstN`, input, 1: synchronous, active-low reset.
- `inValid`, input, 1: operand request valid.
- `inReady`, output, 1: block can accept operands this cycle.
- `a`, input, W: operand A.
- `b`, input, W: operand B.
- `sub`, input, 1: 0 selects A+B; 1 selects A−B.
- `outValid`, output, 1: result valid.
- `outReady`, input, 1: consumer accepts the result.
- `sum`, output, W: result.
- `cOut`, output, 1: carry out of the MSB. For subtraction, 1 = no borrow.
- `ovf`, output, 1: two's-complement signed overflow.
- `zero`, output, 1: `sum` == 0.

## Operation
State machine states are IDLE, RUN and DONE.

**Registers**
- `opA`, `opB`: W bits each.
- `carry`: 1 bit.
- `idx`: ceil(log2 NIBBLES) bits.
- `sumReg`: W bits.
- flag registers for `cOut`, `ovf` and `zero`.

**Accept**
- An accept occurs when `inValid` & `inReady`. It latches:
  - `opA` ← `a`
  - `opB` ← `b` XOR {W{`sub`}}
  - `carry` ← `sub`
  - `idx` ← 0
  - `sumReg` ← 0
- Next state is RUN.

**IDLE**
- `inReady` = 1, `outValid` = 0.
- Stay in IDLE until an accept.

**RUN**
- Slice inputs:
  - x = `opA`[4*idx+3:4*idx]
  - y = `opB`[4*idx+3:4*idx]
  - cIn = `carry`
- Each cycle:
  - `sumReg`[4*idx+3:4*idx] ← slice s
  - `carry` ← slice cOut
  - `idx` ← `idx` + 1
- When `idx` == NIBBLES−1, the cycle's update also captures the flags, then the state goes to DONE:
  - `cOut` ← slice cOut
  - `ovf` ← (`opA`[W−1] == `opB`[W−1]) & (s[3] != `opA`[W−1])
  - `zero` ← (full new sum == 0)
- `inReady` = 0 and `outValid` = 0 throughout RUN.
- Changes on `a`, `b`, `sub` or `inValid` during RUN are ignored.

**DONE**
- `outValid` = 1. `sum`, `cOut`, `ovf` and `zero` are held stable.
- `inReady` = `outReady`, so a new operand set can be accepted in the same cycle the result is consumed.
- If `outReady` & `inValid`: accept the new operands; next state is RUN.
- Else if `outReady`: next state is IDLE.
- Else: stay in DONE, outputs held indefinitely.

**Arithmetic**
- Modulo 2^W.
- Subtraction is A + ~B + 1. The +1 enters through the initial `carry`.

**Reset**
- `rstN` = 0 at a rising edge forces:
  - state = IDLE
  - `idx` = 0, `carry` = 0
  - `sumReg` = 0, `cOut` = 0, `ovf` = 0, `zero` = 0
  - `outValid` = 0
- After reset `inReady` = 1.
- Reset has priority over any handshake in the same cycle. A reset during RUN or DONE discards the operation with no partial output.

## Timing
- Accept in cycle t. RUN occupies cycles t+1 … t+NIBBLES, processing nibble k in cycle t+1+k. `outValid` rises in cycle t+NIBBLES+1.
- Latency is NIBBLES+1 cycles from accept to `outValid`.
- Back-to-back throughput, with `outReady` held high and `inValid` held high, is one result per NIBBLES+1 cycles.
- `sum` is combinationally equal to `sumReg`. It is only meaningful while `outValid` = 1. Partial nibbles may be visible during RUN.
- The combinational path is the slice only: mux, then 4-bit CLA, then register. There is no W-bit carry chain in one cycle.
- `inReady` depends combinationally on `outReady` only in DONE. There is no combinational path from `inValid` to `inReady`.

## Test plan
All scenarios use NIBBLES = 4.
- **Basic add:** after reset, `a`=0x1234, `b`=0x4321, `sub`=0, accepted in cycle 0.
  - Required: `outValid` first high in cycle 5; `sum`=0x5555, `cOut`=0, `ovf`=0, `zero`=0.
- **Full carry ripple:** `a`=0xFFFF, `b`=0x0001, add.
  - Required: `sum`=0x0000, `cOut`=1, `zero`=1, `ovf`=0. This confirms the carry crosses all four slice iterations.
- **Subtract with overflow:** `a`=0x8000, `b`=0x0001, `sub`=1.
  - Required: `sum`=0x7FFF, `cOut`=1, `ovf`=1. A second case, `a`=0x0003, `b`=0x0005, `sub`=1, requires `sum`=0xFFFE, `cOut`=0, `ovf`=0.
- **Backpressure and back-to-back:** hold `outReady`=0 for 3 cycles after `outValid` rises.
  - While `outReady`=0: `sum` and flags are unchanged, `inReady`=0, and operand changes are ignored.
  - Then `outReady`=1 with `inValid`=1 and new operands 0x0F0F+0x0101: the new op is accepted in that cycle, `outValid` drops next cycle, and `sum`=0x1010 appears 5 cycles after the accept.
- **Reset mid-operation:** drive `rstN`=0 for one edge while in RUN at `idx`=2.
  - Required next cycle: `outValid`=0, `inReady`=1, `sum`=0, `cOut`=`ovf`=`zero`=0. A fresh op afterwards completes with the correct result.
- **Random regression:** ≥ 1000 random {`a`, `b`, `sub`} with random `outReady` stalls, compared against a W-bit reference.
  - Checks `sum`, `cOut`, `ovf` and `zero`, plus the exact NIBBLES+1 latency on every result.
